dmem_unit: RTL and testbench

- Data-memory stage directly downstream of the ALU in the single-cycle MIPS datapath.
- Takes the ALU result as the effective address and the rt register value as store data.
- Performs word, halfword and byte loads/stores with sign or zero extension and flags misaligned accesses.
- Drives load data to the write-back mux in the same cycle; stores commit on the clock edge.

---
 rtl/dmem_unit.sv | 126 ++++++++++++
 tb/tb_dmem_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dmem_unit.sv
// Data-memory stage for the single-cycle MIPS datapath.
// Little-endian byte/half/word loads and stores with alignment checking.
module dmem_unit #(
    parameter int DEPTH_LOG2  = 10,
    parameter bit RESET_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic [31:0] store_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            off;
    logic                  misaligned;
    logic                  wr_en;
    logic [3:0]            be;
    logic [31:0]           wlane;
    logic [31:0]           word;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           ext;
    logic                  unused_hi;

    // Upper address bits are dropped so accesses wrap modulo memory size.
    assign idx       = addr[DEPTH_LOG2+1:2];
    assign off       = addr[1:0];
    assign unused_hi = ^addr[31:DEPTH_LOG2+2];

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            default: misaligned = |off;
        endcase
    end

    assign align_err = (mem_we | mem_re) & misaligned;

    // Explicit compare keeps an X on mem_we from acting as a store.
    assign wr_en = (mem_we === 1'b1) && !misaligned;

    always_comb begin
        be    = 4'b0000;
        wlane = wdata;
        case (size)
            2'b00: begin
                be    = 4'b0001 << off;
                wlane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata;
            end
        endcase
    end

    generate
        if (RESET_CLEAR) begin : g_clear
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= '0;
                    end
                end else if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                        end
                    end
                end
            end
        end else begin : g_keep
            always_ff @(posedge clk) begin
                if (wr_en && !rst) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[b]) begin
                            mem[idx][8*b +: 8] <= wlane[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_cnt <= '0;
        end else if (wr_en) begin
            store_cnt <= store_cnt + 32'd1;
        end
    end

    assign word   = mem[idx];
    assign byte_v = word[8*off +: 8];
    assign half_v = off[1] ? word[31:16] : word[15:0];

    always_comb begin
        ext = word;
        case (size)
            2'b00:   ext = sign_ext ? {{24{byte_v[7]}}, byte_v}
                                    : {24'd0, byte_v};
            2'b01:   ext = sign_ext ? {{16{half_v[15]}}, half_v}
                                    : {16'd0, half_v};
            default: ext = word;
        endcase
    end

    assign rdata = (mem_re && !misaligned) ? ext : 32'd0;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed vector bench for dmem_unit: lanes, extension, alignment,
// wrap, read-during-write and asynchronous reset.
module tb_dmem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] rdata;
    logic        align_err;
    logic [31:0] store_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_unit #(.DEPTH_LOG2(10), .RESET_CLEAR(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .wdata     (wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .size      (size),
        .sign_ext  (sign_ext),
        .rdata     (rdata),
        .align_err (align_err),
        .store_cnt (store_cnt)
    );

    typedef struct {
        string       name;
        logic        we;
        logic        re;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a,
                         input logic [31:0] wd);
        mem_we   = we;
        mem_re   = re;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
    endtask

    initial begin
        // name we re sz sx addr wdata exp_rdata exp_err exp_cnt(before edge)
        vecs.push_back('{"sw10",   1,0,2'b10,0,32'h10,  32'hDEADBEEF,32'h0,       0,0});
        vecs.push_back('{"lw10",   0,1,2'b10,0,32'h10,  32'h0,       32'hDEADBEEF,0,1});
        vecs.push_back('{"sw20",   1,0,2'b10,0,32'h20,  32'h807FFF01,32'h0,       0,1});
        vecs.push_back('{"lb23",   0,1,2'b00,1,32'h23,  32'h0,       32'hFFFFFF80,0,2});
        vecs.push_back('{"lbu23",  0,1,2'b00,0,32'h23,  32'h0,       32'h00000080,0,2});
        vecs.push_back('{"lb20",   0,1,2'b00,1,32'h20,  32'h0,       32'h00000001,0,2});
        vecs.push_back('{"lh22",   0,1,2'b01,1,32'h22,  32'h0,       32'hFFFF807F,0,2});
        vecs.push_back('{"lhu22",  0,1,2'b01,0,32'h22,  32'h0,       32'h0000807F,0,2});
        vecs.push_back('{"lh20",   0,1,2'b01,1,32'h20,  32'h0,       32'hFFFFFF01,0,2});
        vecs.push_back('{"sw30",   1,0,2'b10,0,32'h30,  32'h11223344,32'h0,       0,2});
        vecs.push_back('{"sb31",   1,0,2'b00,0,32'h31,  32'h000000AA,32'h0,       0,3});
        vecs.push_back('{"sh32",   1,0,2'b01,0,32'h32,  32'h0000BEEF,32'h0,       0,4});
        vecs.push_back('{"lw30",   0,1,2'b10,0,32'h30,  32'h0,       32'hBEEFAA44,0,5});
        vecs.push_back('{"sw40",   1,0,2'b10,0,32'h40,  32'h12345678,32'h0,       0,5});
        vecs.push_back('{"sw42",   1,0,2'b10,0,32'h42,  32'hFFFFFFFF,32'h0,       1,6});
        vecs.push_back('{"lw40",   0,1,2'b10,0,32'h40,  32'h0,       32'h12345678,0,6});
        vecs.push_back('{"lh41",   0,1,2'b01,1,32'h41,  32'h0,       32'h0,       1,6});
        vecs.push_back('{"idle43", 0,0,2'b10,0,32'h43,  32'h0,       32'h0,       0,6});
        vecs.push_back('{"lw40s3", 0,1,2'b11,1,32'h40,  32'h0,       32'h12345678,0,6});
        vecs.push_back('{"lw41s3", 0,1,2'b11,0,32'h41,  32'h0,       32'h0,       1,6});
        vecs.push_back('{"sw0",    1,0,2'b10,0,32'h0,   32'h5,       32'h0,       0,6});
        vecs.push_back('{"lw1000", 0,1,2'b10,0,32'h1000,32'h0,       32'h5,       0,7});
        vecs.push_back('{"rdw0",   1,1,2'b10,0,32'h0,   32'h9,       32'h5,       0,7});
        vecs.push_back('{"lw0",    0,1,2'b10,0,32'h0,   32'h0,       32'h9,       0,8});

        rst = 1'b1;
        drive(0, 1, 2'b10, 0, 32'h10, 32'h0);
        @(negedge clk);
        #2;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_cnt", store_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].sx,
                  vecs[i].a, vecs[i].wd);
            #2;
            chk({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rd);
            chk({vecs[i].name, "_err"}, {31'd0, align_err},
                {31'd0, vecs[i].exp_err});
            chk({vecs[i].name, "_cnt"}, store_cnt, vecs[i].exp_cnt);
        end

        // Asynchronous reset between edges clears array and counter at once.
        @(negedge clk);
        drive(0, 1, 2'b10, 0, 32'h10, 32'h0);
        #1;
        chk("pre_rst_lw10", rdata, 32'hDEADBEEF);
        chk("pre_rst_cnt", store_cnt, 32'd8);
        rst = 1'b1;
        #1;
        chk("async_cnt", store_cnt, 32'h0);
        chk("async_lw10", rdata, 32'h0);
        addr = 32'h30;
        #1;
        chk("async_lw30", rdata, 32'h0);
        chk("async_err", {31'd0, align_err}, 32'h0);

        // Store request held through an edge while in reset: no effect.
        drive(1, 0, 2'b10, 0, 32'h8, 32'h77);
        @(posedge clk);
        #1;
        chk("rst_store_cnt", store_cnt, 32'h0);
        @(negedge clk);
        drive(0, 1, 2'b10, 0, 32'h8, 32'h0);
        #1;
        chk("rst_store_mem", rdata, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_lw8", rdata, 32'h0);

        // First store after release commits on the next edge.
        drive(1, 0, 2'b10, 0, 32'h8, 32'h77);
        @(posedge clk);
        #1;
        chk("first_store_cnt", store_cnt, 32'd1);
        drive(0, 1, 2'b10, 0, 32'h8, 32'h0);
        #1;
        chk("first_store_lw8", rdata, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
